// File: rtl/mux_scan_if.sv
// Scan-controller bus: start request, selector select/output pair, and the result valid/ready handshake.
interface mux_scan_if;
    logic       start;
    logic [1:0] sel;
    logic       y_in;
    logic       busy;
    logic [3:0] data;
    logic       valid;
    logic       ready;

    modport master (
        input  start, y_in, ready,
        output sel, busy, data, valid
    );

    modport slave (
        output start, y_in, ready,
        input  sel, busy, data, valid
    );
endinterface

// File: rtl/mux_scan.sv
// Scan controller around a 4-to-1 selector: steps sel 0..3, waits SETTLE cycles per lane, assembles a 4-bit word.
// Optional MUX_SCAN_CONTINUOUS_EN: a handshake in HOLD restarts the scan immediately instead of returning to IDLE.
module mux_scan #(
    parameter int unsigned SETTLE = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_scan_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, HOLD} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            bus.sel   <= '0;
            bus.data  <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.sel <= '0;
                    if (bus.start) begin
                        state    <= WAIT;
                        cnt      <= RELOAD;
                        bus.busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    shreg[bus.sel] <= bus.y_in;
                    if (bus.sel != 2'd3) begin
                        bus.sel <= bus.sel + 2'd1;
                        cnt     <= RELOAD;
                        state   <= WAIT;
                    end else begin
                        // Lane 3 goes straight into data; shreg[3] is only written for consistency.
                        bus.data  <= {bus.y_in, shreg[2:0]};
                        bus.valid <= 1'b1;
                        bus.busy  <= 1'b0;
                        bus.sel   <= '0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ready) begin
                        bus.valid <= 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                        state    <= WAIT;
                        cnt      <= RELOAD;
                        bus.sel  <= '0;
                        bus.busy <= 1'b1;
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: two instances (SETTLE=2 and SETTLE=1), each behind a behavioural 4-to-1 selector.
module tb_mux_scan;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] a2;
    logic [3:0] a1;
    int unsigned tests = 0;
    int unsigned fails = 0;

`ifdef MUX_SCAN_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    mux_scan_if bus2();
    mux_scan_if bus1();

    assign bus2.y_in = a2[bus2.sel];
    assign bus1.y_in = a1[bus1.sel];

    mux_scan #(.SETTLE(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    mux_scan #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Brief async reset so every scenario starts from IDLE in either build.
    task automatic quiesce();
        @(negedge clk);
        rst_n = 1'b0;
        bus2.start = 1'b0;
        bus1.start = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus2.start = 1'b0; bus2.ready = 1'b0; bus1.start = 1'b0; bus1.ready = 1'b0;
        a2 = 4'h0; a1 = 4'h0;
        #12;
        tests++; if (bus2.sel !== 2'd0) begin fails++; $display("FAIL reset_sel: got %0d expected 0", bus2.sel); end
        tests++; if (bus2.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus2.busy); end
        tests++; if (bus2.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus2.valid); end
        tests++; if (bus2.data !== 4'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", bus2.data); end
        tests++; if (bus1.valid !== 1'b0 || bus1.data !== 4'h0) begin fails++; $display("FAIL reset_dut1: got valid %b data %h expected 0/0", bus1.valid, bus1.data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [1:0] esel;
        logic ev, eb;
        quiesce();
        a2 = 4'b1010; bus2.ready = 1'b1; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        tests++; if (bus2.busy !== 1'b1 || bus2.sel !== 2'd0 || bus2.valid !== 1'b0) begin fails++; $display("FAIL single_e0: got busy %b sel %0d valid %b expected 1/0/0", bus2.busy, bus2.sel, bus2.valid); end
        for (int k = 1; k <= 13; k++) begin
            tick();
            esel = (k < 12) ? 2'(k / 3) : 2'd0;
            ev = (k == 12);
            eb = (k < 12) || (k == 13 && CONT);
            tests++; if (bus2.sel !== esel) begin fails++; $display("FAIL single_sel@%0d: got %0d expected %0d", k, bus2.sel, esel); end
            tests++; if (bus2.valid !== ev) begin fails++; $display("FAIL single_valid@%0d: got %b expected %b", k, bus2.valid, ev); end
            tests++; if (bus2.busy !== eb) begin fails++; $display("FAIL single_busy@%0d: got %b expected %b", k, bus2.busy, eb); end
            if (k >= 12) begin
                tests++; if (bus2.data !== 4'b1010) begin fails++; $display("FAIL single_data@%0d: got %b expected 1010", k, bus2.data); end
            end
        end
    endtask

    task automatic test_backpressure();
        quiesce();
        a2 = 4'b0110; bus2.ready = 1'b0; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) a2 = 4'b1111;
            tests++; if (bus2.valid !== 1'b1 || bus2.data !== 4'b0110) begin fails++; $display("FAIL bp_hold@%0d: got valid %b data %b expected 1/0110", i, bus2.valid, bus2.data); end
            tests++; if (bus2.sel !== 2'd0 || bus2.busy !== 1'b0) begin fails++; $display("FAIL bp_sel_busy@%0d: got sel %0d busy %b expected 0/0", i, bus2.sel, bus2.busy); end
            tick();
        end
        bus2.ready = 1'b1;
        tick();
        tests++; if (bus2.valid !== 1'b0) begin fails++; $display("FAIL bp_release: got valid %b expected 0", bus2.valid); end
        tests++; if (bus2.data !== 4'b0110) begin fails++; $display("FAIL bp_data_kept: got %b expected 0110", bus2.data); end
    endtask

    task automatic test_ignored_start();
        int unsigned npulse;
        logic ev;
        npulse = 0;
        quiesce();
        a2 = 4'b0001; bus2.ready = 1'b1; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            bus2.start = (k == 3 || k == 7);
            tick();
            bus2.start = 1'b0;
            ev = (k == 12) || (CONT && k == 25);
            tests++; if (bus2.valid !== ev) begin fails++; $display("FAIL ign_valid@%0d: got %b expected %b", k, bus2.valid, ev); end
            if (bus2.valid === 1'b1) begin
                npulse++;
                tests++; if (bus2.data !== 4'b0001) begin fails++; $display("FAIL ign_data@%0d: got %b expected 0001", k, bus2.data); end
            end
        end
        tests++; if (npulse != (CONT ? 2 : 1)) begin fails++; $display("FAIL ign_pulses: got %0d expected %0d", npulse, CONT ? 2 : 1); end
    endtask

    task automatic test_async_reset();
        quiesce();
        a2 = 4'b1010; bus2.ready = 1'b0; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        repeat (12) tick();
        tests++; if (bus2.valid !== 1'b1 || bus2.data !== 4'b1010) begin fails++; $display("FAIL ar_pre: got valid %b data %b expected 1/1010", bus2.valid, bus2.data); end
        a2 = 4'b1111; bus2.ready = 1'b1; bus2.start = 1'b1;
        tick();
`ifndef MUX_SCAN_CONTINUOUS_EN
        tick();
`endif
        bus2.start = 1'b0; bus2.ready = 1'b0;
        repeat (7) tick();
        tests++; if (bus2.sel !== 2'd2 || bus2.busy !== 1'b1) begin fails++; $display("FAIL ar_lane2: got sel %0d busy %b expected 2/1", bus2.sel, bus2.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus2.sel !== 2'd0 || bus2.busy !== 1'b0) begin fails++; $display("FAIL ar_sel_busy: got sel %0d busy %b expected 0/0", bus2.sel, bus2.busy); end
        tests++; if (bus2.valid !== 1'b0 || bus2.data !== 4'h0) begin fails++; $display("FAIL ar_valid_data: got valid %b data %b expected 0/0000", bus2.valid, bus2.data); end
        @(negedge clk);
        rst_n = 1'b1;
        a2 = 4'b0101; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        repeat (11) tick();
        tests++; if (bus2.valid !== 1'b0) begin fails++; $display("FAIL ar_early: got valid %b expected 0", bus2.valid); end
        tick();
        tests++; if (bus2.valid !== 1'b1 || bus2.data !== 4'b0101) begin fails++; $display("FAIL ar_rescan: got valid %b data %b expected 1/0101", bus2.valid, bus2.data); end
    endtask

    task automatic test_settle_boundary();
        logic [3:0] tgt;
        logic [3:0] noise;
        logic ev;
        tgt = 4'b1001;
        noise = 4'b0000;
        quiesce();
        bus1.ready = 1'b1;
        a1 = noise; a1[bus1.sel] = tgt[bus1.sel];
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            noise = ~noise;
            a1 = noise; a1[bus1.sel] = tgt[bus1.sel];
            tick();
            ev = (k == 8);
            tests++; if (bus1.valid !== ev) begin fails++; $display("FAIL settle_valid@%0d: got %b expected %b", k, bus1.valid, ev); end
            if (k == 8) begin
                tests++; if (bus1.data !== tgt) begin fails++; $display("FAIL settle_data: got %b expected %b", bus1.data, tgt); end
            end
        end
    endtask

    task automatic test_continuous();
        int unsigned npulse;
        logic ev;
        npulse = 0;
        quiesce();
        a2 = 4'b1100; bus2.ready = 1'b1; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            ev = (k == 12) || (CONT && (k == 25 || k == 38));
            tests++; if (bus2.valid !== ev) begin fails++; $display("FAIL cont_valid@%0d: got %b expected %b", k, bus2.valid, ev); end
            if (bus2.valid === 1'b1) begin
                npulse++;
                tests++; if (bus2.data !== 4'b1100) begin fails++; $display("FAIL cont_data@%0d: got %b expected 1100", k, bus2.data); end
            end
            if (k == 13) begin
                tests++; if (bus2.busy !== CONT) begin fails++; $display("FAIL cont_busy@13: got %b expected %b", bus2.busy, CONT); end
            end
        end
        tests++; if (npulse != (CONT ? 3 : 1)) begin fails++; $display("FAIL cont_pulses: got %0d expected %0d", npulse, CONT ? 3 : 1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_ignored_start();
        test_async_reset();
        test_settle_boundary();
        test_continuous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
